// File: rtl/prod_accum_kh.sv
// prod_accum_kh: sums N_TERMS products per frame behind valid/ready handshakes.
// Optional build macro PROD_ACCUM_SATURATE_EN clamps the sum instead of wrapping it.
module prod_accum_kh #(
  parameter int N_TERMS = 4,
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        term_cnt
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n, sum_n, res;
  logic [ACC_W:0] add;
  logic [7:0] cnt_n;
  logic ov_n, accept, last;
  assign in_ready = (state == ACCUM) && !clr;
  assign accept = in_valid && in_ready;
  assign last = term_cnt == 8'(N_TERMS - 1);
  assign add = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
`ifdef PROD_ACCUM_SATURATE_EN
  assign res = add[ACC_W] ? '1 : add[ACC_W-1:0];
`else
  assign res = add[ACC_W-1:0];
`endif
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = term_cnt;
    sum_n = sum;
    ov_n = out_valid;
    if (clr) begin
      acc_n = '0;
      cnt_n = '0;
      ov_n = 1'b0;
      state_n = ACCUM;
    end else if (accept) begin
      acc_n = last ? '0 : res;
      cnt_n = last ? 8'd0 : term_cnt + 8'd1;
      sum_n = last ? res : sum;
      ov_n = last;
      state_n = last ? HOLD : ACCUM;
    end else if (state == HOLD && out_ready) begin
      ov_n = 1'b0;
      state_n = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      acc <= '0;
      term_cnt <= '0;
      sum <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      term_cnt <= cnt_n;
      sum <= sum_n;
      out_valid <= ov_n;
    end
  end
endmodule

// File: tb/tb_prod_accum_kh.sv
// tb_prod_accum_kh: directed checks of prod_accum_kh, default and 17-bit/3-term instances.
module tb_prod_accum_kh;
  logic clk = 1'b0, reset, in_valid, clr, out_ready, b_valid;
  logic [15:0] prod, b_prod;
  logic in_ready, out_valid, b_ready, b_ovalid;
  logic [19:0] sum;
  logic [16:0] b_sum;
  logic [7:0] term_cnt, b_cnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  prod_accum_kh dut (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
    .clr(clr), .sum(sum), .out_valid(out_valid), .out_ready(out_ready), .term_cnt(term_cnt)
  );
  prod_accum_kh #(.N_TERMS(3), .ACC_W(17)) dut_b (
    .clk(clk), .reset(reset), .prod(b_prod), .in_valid(b_valid), .in_ready(b_ready),
    .clr(clr), .sum(b_sum), .out_valid(b_ovalid), .out_ready(out_ready), .term_cnt(b_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; in_valid = 1; prod = 16'hFFFF; clr = 0; out_ready = 0; b_valid = 0; b_prod = 0;
    step();
    step();
    chk("rst_sum", sum, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_cnt", term_cnt, 0);
    reset = 0; in_valid = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    in_valid = 1; prod = 16'd65025; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("fs_ready", in_ready, 1);
      chk("fs_cnt", term_cnt, i);
      step();
    end
    in_valid = 0;
    chk("fs_ov", out_valid, 1);
    chk("fs_sum", sum, 260100);
    chk("fs_ready_hold", in_ready, 0);
    step();
    chk("fs_ov_drop", out_valid, 0);
    chk("fs_ready_back", in_ready, 1);
    out_ready = 0; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      prod = 16'(i);
      step();
    end
    prod = 16'd7;
    for (int i = 0; i < 4; i++) begin
      out_ready = (i == 3);
      chk("bp_sum", sum, 10);
      chk("bp_ov", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      step();
    end
    in_valid = 0;
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_cnt", term_cnt, 0);
    in_valid = 1; prod = 16'd100;
    step();
    prod = 16'd200;
    step();
    chk("ab_cnt", term_cnt, 2);
    clr = 1; prod = 16'd999;
    #1;
    chk("ab_ready", in_ready, 0);
    step();
    clr = 0;
    chk("ab_cnt_clr", term_cnt, 0);
    chk("ab_ov", out_valid, 0);
    prod = 16'd5;
    for (int i = 0; i < 4; i++) begin
      chk("ab_no_out", out_valid, 0);
      step();
    end
    in_valid = 0;
    chk("ab_sum", sum, 20);
    chk("ab_sum_ov", out_valid, 1);
    step();
    out_ready = 0; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      prod = 16'(i);
      step();
    end
    in_valid = 0;
    chk("mh_ov", out_valid, 1);
    reset = 1;
    step();
    reset = 0;
    chk("mh_ov_rst", out_valid, 0);
    chk("mh_sum_rst", sum, 0);
    chk("mh_cnt_rst", term_cnt, 0);
    in_valid = 1; prod = 16'd1; out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    in_valid = 0;
    chk("mh_sum", sum, 4);
    chk("mh_sum_ov", out_valid, 1);
    step();
    b_valid = 1; b_prod = 16'd65025;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_cnt", b_cnt, i);
      step();
    end
    b_valid = 0;
    chk("ovf_ov", b_ovalid, 1);
`ifdef PROD_ACCUM_SATURATE_EN
    chk("ovf_sum", b_sum, 131071);
`else
    chk("ovf_sum", b_sum, 64003);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
